// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the multiport register file.
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } rf_state_e;

    localparam int RF_DATA_W   = 32;
    localparam int RF_DEPTH    = 32;
    localparam int RF_NUM_READ = 2;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: set by issue, cleared by writeback, flushed on reset/clear.
module regfile_scoreboard #(
    parameter int DEPTH    = 32,
    parameter int NUM_READ = 2,
    parameter int ADDR_W   = $clog2(DEPTH)
) (
    input  logic                       Clock,
    input  logic                       i_flush,
    input  logic                       i_set,
    input  logic [ADDR_W-1:0]          i_set_addr,
    input  logic                       i_clr,
    input  logic [ADDR_W-1:0]          i_clr_addr,
    input  logic [NUM_READ*ADDR_W-1:0] i_lookup_addr,
    output logic [NUM_READ-1:0]        o_busy
);

    logic [DEPTH-1:0] r_busy;

    // Set is applied after clear so a new producer wins over a same-cycle writeback.
    always_ff @(posedge Clock) begin
        if (i_flush) begin
            r_busy <= '0;
        end else begin
            if (i_clr) r_busy[i_clr_addr] <= 1'b0;
            if (i_set) r_busy[i_set_addr] <= 1'b1;
        end
    end

    for (genvar p = 0; p < NUM_READ; p++) begin : g_lookup
        assign o_busy[p] = r_busy[i_lookup_addr[p*ADDR_W +: ADDR_W]];
    end

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised multiport register file with pending bits and a sequenced clear sweep.
// Optional same-cycle write-to-read bypass enabled by defining REGFILE_BYPASS_EN.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int DEPTH    = RF_DEPTH,
    parameter int NUM_READ = RF_NUM_READ,
    parameter int ZERO_REG = 1,
    parameter int ADDR_W   = $clog2(DEPTH)
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       Clear,
    output logic                       Ready,
    input  logic [NUM_READ*ADDR_W-1:0] ReadAddr,
    output logic [NUM_READ*DATA_W-1:0] ReadData,
    output logic [NUM_READ-1:0]        ReadBusy,
    input  logic                       RegWrite,
    input  logic [ADDR_W-1:0]          WriteAddr,
    input  logic [DATA_W-1:0]          WriteData,
    input  logic                       Reserve,
    input  logic [ADDR_W-1:0]          ReserveAddr
);

    logic [DATA_W-1:0]   r_mem [DEPTH];
    rf_state_e           r_state;
    logic [ADDR_W-1:0]   r_idx;
    logic                r_ready;

    logic                w_flush;
    logic                w_wr_commit;
    logic                w_rsv;
    logic [NUM_READ-1:0] w_sb_busy;

    assign w_flush     = Reset | (Clear & (r_state == IDLE));
    assign w_wr_commit = RegWrite & r_ready & ~w_flush
                       & ~((ZERO_REG != 0) && (WriteAddr == '0));
    assign w_rsv       = Reserve & r_ready & ~w_flush
                       & ~((ZERO_REG != 0) && (ReserveAddr == '0));
    assign Ready       = r_ready;

    always_ff @(posedge Clock) begin
        if (w_flush) begin
            r_state <= SWEEP;
            r_idx   <= '0;
            r_ready <= 1'b0;
        end else if (r_state == SWEEP) begin
            r_idx <= r_idx + 1'b1;
            if (r_idx == ADDR_W'(DEPTH - 1)) begin
                r_state <= IDLE;
                r_ready <= 1'b1;
            end
        end
    end

    // Contents are never reset directly; the sweep zeroes one entry per cycle.
    always_ff @(posedge Clock) begin
        if (r_state == SWEEP && !Reset) begin
            r_mem[r_idx] <= '0;
        end else if (w_wr_commit) begin
            r_mem[WriteAddr] <= WriteData;
        end
    end

    regfile_scoreboard #(
        .DEPTH    (DEPTH),
        .NUM_READ (NUM_READ),
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .Clock         (Clock),
        .i_flush       (w_flush),
        .i_set         (w_rsv),
        .i_set_addr    (ReserveAddr),
        .i_clr         (w_wr_commit),
        .i_clr_addr    (WriteAddr),
        .i_lookup_addr (ReadAddr),
        .o_busy        (w_sb_busy)
    );

    for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_data;
        logic              w_busy;

        assign w_addr = ReadAddr[p*ADDR_W +: ADDR_W];

        always_comb begin
            w_data = r_mem[w_addr];
            w_busy = w_sb_busy[p];
`ifdef REGFILE_BYPASS_EN
            if (w_wr_commit && (w_addr == WriteAddr)) begin
                w_data = WriteData;
                w_busy = w_rsv && (ReserveAddr == w_addr);
            end
`endif
            if (!r_ready || ((ZERO_REG != 0) && (w_addr == '0))) begin
                w_data = '0;
                w_busy = 1'b0;
            end
        end

        assign ReadData[p*DATA_W +: DATA_W] = w_data;
        assign ReadBusy[p]                  = w_busy;
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed self-checking bench for regfile_multiport (default 32x32, two read ports).
module tb_regfile_multiport;

    logic        Clock = 1'b0;
    logic        Reset, Clear, Ready;
    logic [9:0]  ReadAddr;
    logic [63:0] ReadData;
    logic [1:0]  ReadBusy;
    logic        RegWrite, Reserve;
    logic [4:0]  WriteAddr, ReserveAddr;
    logic [31:0] WriteData;

    int n_checks = 0;
    int n_errors = 0;

    regfile_multiport dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Clear       (Clear),
        .Ready       (Ready),
        .ReadAddr    (ReadAddr),
        .ReadData    (ReadData),
        .ReadBusy    (ReadBusy),
        .RegWrite    (RegWrite),
        .WriteAddr   (WriteAddr),
        .WriteData   (WriteData),
        .Reserve     (Reserve),
        .ReserveAddr (ReserveAddr)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        ReadAddr = {a1, a0};
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        Reset = 1'b1; Clear = 1'b0; ReadAddr = '0;
        RegWrite = 1'b0; WriteAddr = '0; WriteData = '0;
        Reserve = 1'b0; ReserveAddr = '0;

        // Power-up reset and full sweep
        tick();
        Reset = 1'b0;
        for (int i = 0; i < 31; i++) begin
            rd(5'(i), 5'(31 - i));
            chk("init_ready", 32'(Ready), 32'd0);
            chk("init_rd0", ReadData[31:0], 32'd0);
            chk("init_rd1", ReadData[63:32], 32'd0);
            chk("init_busy", 32'(ReadBusy), 32'd0);
            tick();
        end
        chk("init_ready_31", 32'(Ready), 32'd0);
        tick();
        chk("init_ready_32", 32'(Ready), 32'd1);
        rd(5'd31, 5'd1);
        chk("post_sweep_r31", ReadData[31:0], 32'd0);

        // Basic write, dual read, zero register
        RegWrite = 1'b1; WriteAddr = 5'd5; WriteData = 32'hDEADBEEF;
        tick();
        RegWrite = 1'b0;
        rd(5'd5, 5'd5);
        chk("r5_p0", ReadData[31:0], 32'hDEADBEEF);
        chk("r5_p1", ReadData[63:32], 32'hDEADBEEF);
        RegWrite = 1'b1; WriteAddr = 5'd0; WriteData = 32'h1234;
        tick();
        RegWrite = 1'b0;
        rd(5'd0, 5'd5);
        chk("r0_zero", ReadData[31:0], 32'd0);
        chk("r0_busy", 32'(ReadBusy), 32'd0);

        // Same-cycle write and read of r7
        RegWrite = 1'b1; WriteAddr = 5'd7; WriteData = 32'h11111111;
        tick();
        WriteData = 32'hA5A5A5A5;
        rd(5'd7, 5'd7);
`ifdef REGFILE_BYPASS_EN
        chk("r7_same_cycle", ReadData[31:0], 32'hA5A5A5A5);
`else
        chk("r7_same_cycle", ReadData[31:0], 32'h11111111);
`endif
        tick();
        RegWrite = 1'b0;
        #1;
        chk("r7_next_cycle", ReadData[63:32], 32'hA5A5A5A5);

        // Reservations on r9
        Reserve = 1'b1; ReserveAddr = 5'd9;
        tick();
        Reserve = 1'b0;
        rd(5'd9, 5'd8);
        chk("r9_busy", 32'(ReadBusy), 32'b01);
        RegWrite = 1'b1; WriteAddr = 5'd9; WriteData = 32'h99;
        rd(5'd9, 5'd9);
`ifdef REGFILE_BYPASS_EN
        chk("r9_busy_wr_cycle", 32'(ReadBusy), 32'b00);
`else
        chk("r9_busy_wr_cycle", 32'(ReadBusy), 32'b11);
`endif
        tick();
        RegWrite = 1'b0;
        #1;
        chk("r9_busy_cleared", 32'(ReadBusy), 32'b00);
        chk("r9_data", ReadData[31:0], 32'h99);
        RegWrite = 1'b1; WriteData = 32'h77;
        Reserve = 1'b1; ReserveAddr = 5'd9;
        tick();
        RegWrite = 1'b0; Reserve = 1'b0;
        #1;
        chk("r9_rsv_wr_data", ReadData[31:0], 32'h77);
        chk("r9_rsv_wr_busy", 32'(ReadBusy), 32'b11);

        // Clear sweep with r3 written and r4 pending; Clear during sweep is ignored
        RegWrite = 1'b1; WriteAddr = 5'd3; WriteData = 32'h55;
        Reserve = 1'b1; ReserveAddr = 5'd4;
        tick();
        RegWrite = 1'b0; Reserve = 1'b0;
        rd(5'd3, 5'd4);
        chk("r3_pre_clear", ReadData[31:0], 32'h55);
        chk("r4_busy_pre_clear", 32'(ReadBusy), 32'b10);
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        for (int i = 0; i < 31; i++) begin
            Clear = (i == 10);
            #1;
            chk("clr_ready", 32'(Ready), 32'd0);
            chk("clr_rd_zero", ReadData[31:0], 32'd0);
            tick();
        end
        Clear = 1'b0;
        #1;
        chk("clr_ready_31", 32'(Ready), 32'd0);
        tick();
        chk("clr_ready_32", 32'(Ready), 32'd1);
        rd(5'd3, 5'd4);
        chk("r3_post_clear", ReadData[31:0], 32'd0);
        chk("r4_busy_post_clear", 32'(ReadBusy), 32'b00);

        // Reset restart mid-sweep; write during sweep is dropped
        RegWrite = 1'b1; WriteAddr = 5'd5; WriteData = 32'hDEADBEEF;
        Reserve = 1'b1; ReserveAddr = 5'd9;
        tick();
        RegWrite = 1'b0; Reserve = 1'b0;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        rd(5'd5, 5'd9);
        chk("sweep_rd_gated", ReadData[31:0], 32'd0);
        chk("sweep_busy_gated", 32'(ReadBusy), 32'b00);
        for (int i = 0; i < 10; i++) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        for (int i = 0; i < 31; i++) begin
            RegWrite = (i == 20); WriteAddr = 5'd2; WriteData = 32'hCAFE;
            #1;
            chk("rst_ready", 32'(Ready), 32'd0);
            tick();
        end
        RegWrite = 1'b0;
        #1;
        chk("rst_ready_31", 32'(Ready), 32'd0);
        tick();
        chk("rst_ready_32", 32'(Ready), 32'd1);
        rd(5'd2, 5'd5);
        chk("r2_not_stored", ReadData[31:0], 32'd0);
        chk("r5_swept", ReadData[63:32], 32'd0);
        rd(5'd9, 5'd9);
        chk("r9_busy_after_reset", 32'(ReadBusy), 32'b00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
